// File: rtl/lcd_bus_writer.sv
// Purpose: performs one complete HD44780-style LCD write (setup, enable pulse, hold, execution wait) per istart rising edge.
// Latency: SETUP_CYC+EN_CYC+HOLD_CYC+EXEC_CYC cycles (8-bit), twice the strobe part in 4-bit mode; LONG_CYC replaces EXEC_CYC for clear/home.
// Backpressure: obusy is high for the whole write; start edges seen while busy are dropped, never queued.
module lcd_bus_writer #(
    parameter int BUS4      = 0,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 26,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int CNT_W     = 17
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic [7:0] idata,
    input  logic       irs,
    input  logic       istart,
    output logic       obusy,
    output logic       odone,
    output logic [7:0] lcd_data,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_rs
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    // Terminal counts: each phase counts 0 .. N-1 and leaves on the last value.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);
    localparam logic             NIB_MODE   = (BUS4 != 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       dat_q, dat_nxt;
    logic [7:0]       lcd_data_nxt;
    logic             lcd_rs_nxt, lcd_en_nxt;
    logic             busy_nxt, done_nxt;
    logic             nib, nib_nxt;
    logic             prestart;
    logic             start_edge;
    logic             long_wait;
    logic [CNT_W-1:0] exec_last;

    assign lcd_rw     = 1'b0;
    assign start_edge = istart & ~prestart;

    // Clear display (0x01) and return home (0x02/0x03) instructions need the long wait.
    assign long_wait  = ~lcd_rs & (((dat_q[7:1] == 7'b0000000) & dat_q[0]) |
                                   (dat_q[7:1] == 7'b0000001));
    assign exec_last  = long_wait ? LONG_LAST : EXEC_LAST;

    // Registers: prestart resets high so a start held through reset release is not an edge.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dat_q    <= 8'h00;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            obusy    <= 1'b0;
            odone    <= 1'b0;
            nib      <= 1'b0;
            prestart <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dat_q    <= dat_nxt;
            lcd_data <= lcd_data_nxt;
            lcd_rs   <= lcd_rs_nxt;
            lcd_en   <= lcd_en_nxt;
            obusy    <= busy_nxt;
            odone    <= done_nxt;
            nib      <= nib_nxt;
            prestart <= istart;
        end
    end

    // Next-state and output logic; every register holds unless a phase boundary changes it.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dat_nxt      = dat_q;
        lcd_data_nxt = lcd_data;
        lcd_rs_nxt   = lcd_rs;
        lcd_en_nxt   = lcd_en;
        busy_nxt     = obusy;
        done_nxt     = odone;
        nib_nxt      = nib;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    dat_nxt      = idata;
                    lcd_rs_nxt   = irs;
                    lcd_data_nxt = NIB_MODE ? {idata[7:4], 4'b0000} : idata;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    nib_nxt      = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt    = '0;
                    lcd_en_nxt = 1'b1;
                    state_nxt  = EN_HI;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            EN_HI: begin
                if (cnt == EN_LAST) begin
                    cnt_nxt    = '0;
                    lcd_en_nxt = 1'b0;
                    state_nxt  = HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt = '0;
                    if (NIB_MODE && !nib) begin
                        lcd_data_nxt = {dat_q[3:0], 4'b0000};
                        nib_nxt      = 1'b1;
                        state_nxt    = SETUP;
                    end else begin
                        state_nxt = EXEC;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                if (cnt == exec_last) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
module tb_lcd_bus_writer;

    logic       clk;
    logic       irst_n;
    logic [7:0] idata;
    logic       irs;
    logic       istart0, istart1;

    logic       busy0, done0, rw0, en0, rs0;
    logic [7:0] data0;
    logic       busy1, done1, rw1, en1, rs1;
    logic [7:0] data1;

    int errors = 0;
    int checks = 0;
    int rw_bad = 0;

    // Monitor mux selecting which instance the write task observes.
    int         sel_mon = 0;
    logic       m_en, m_busy, m_done, m_rs;
    logic [7:0] m_data;

    // Results of the last monitored write.
    int         r_lat, r_pulses, r_enhi, r_first, r_busy, r_dbad;
    logic [7:0] r_pdata0, r_pdata1;

    lcd_bus_writer #(.BUS4(0), .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2),
                     .EXEC_CYC(10), .LONG_CYC(30), .CNT_W(8)) dut0 (
        .iclk(clk), .irst_n(irst_n), .idata(idata), .irs(irs), .istart(istart0),
        .obusy(busy0), .odone(done0), .lcd_data(data0), .lcd_rw(rw0),
        .lcd_en(en0), .lcd_rs(rs0)
    );

    lcd_bus_writer #(.BUS4(1), .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2),
                     .EXEC_CYC(10), .LONG_CYC(30), .CNT_W(8)) dut1 (
        .iclk(clk), .irst_n(irst_n), .idata(idata), .irs(irs), .istart(istart1),
        .obusy(busy1), .odone(done1), .lcd_data(data1), .lcd_rw(rw1),
        .lcd_en(en1), .lcd_rs(rs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_en   = (sel_mon == 0) ? en0   : en1;
        m_busy = (sel_mon == 0) ? busy0 : busy1;
        m_done = (sel_mon == 0) ? done0 : done1;
        m_rs   = (sel_mon == 0) ? rs0   : rs1;
        m_data = (sel_mon == 0) ? data0 : data1;
    end

    // lcd_rw must stay low for the whole run.
    always @(negedge clk) begin
        if (rw0 !== 1'b0 || rw1 !== 1'b0) rw_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) istart0 = v;
        else          istart1 = v;
    endtask

    // One write on the selected instance; k counts cycles after the accept edge.
    // An optional extra start pulse is raised at k == extra_at.
    task automatic do_write(input int sel, input logic [7:0] d, input logic rs, input int extra_at);
        logic       prev_en;
        logic [7:0] cur;
        sel_mon  = sel;
        idata    = d;
        irs      = rs;
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        r_lat = -1; r_pulses = 0; r_enhi = 0; r_first = -1; r_busy = 0; r_dbad = 0;
        r_pdata0 = 8'h00; r_pdata1 = 8'h00;
        prev_en = 1'b0;
        cur     = 8'h00;
        for (int k = 0; k < 200; k++) begin
            if (k == extra_at)     set_start(sel, 1'b1);
            if (k == extra_at + 1) set_start(sel, 1'b0);
            if (m_done) begin
                r_lat = k;
                break;
            end
            if (m_busy) r_busy++;
            if (m_en) begin
                r_enhi++;
                if (!prev_en) begin
                    if (r_first < 0) r_first = k;
                    if (r_pulses == 0) r_pdata0 = m_data;
                    else               r_pdata1 = m_data;
                    cur = m_data;
                    r_pulses++;
                end else if (m_data !== cur) begin
                    r_dbad++;
                end
            end
            prev_en = m_en;
            step();
        end
        istart0 = 1'b0;
        istart1 = 1'b0;
    endtask

    initial begin
        int pulses;
        int done_rises;
        logic prev_en;
        logic prev_done;
        int seen;

        irst_n  = 1'b0;
        idata   = 8'h00;
        irs     = 1'b0;
        istart0 = 1'b0;
        istart1 = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_en0",   en0,   0);
        check("rst_data0", data0, 8'h00);
        check("rst_rs0",   rs0,   0);
        check("rst_en1",   en1,   0);
        check("rst_data1", data1, 8'h00);
        irst_n = 1'b1;
        repeat (2) step();
        check("post_rst_idle", busy0, 0);

        // 8-bit data write
        do_write(0, 8'h41, 1'b1, -1);
        check("w41_lat",    r_lat,    18);
        check("w41_pulses", r_pulses, 1);
        check("w41_enhi",   r_enhi,   4);
        check("w41_first",  r_first,  2);
        check("w41_busy",   r_busy,   18);
        check("w41_data",   r_pdata0, 8'h41);
        check("w41_dstable", r_dbad,  0);
        check("w41_rs",     m_rs,     1);
        check("w41_busy_end", busy0,  0);
        check("w41_hold_data", data0, 8'h41);

        // Long wait for clear/home, normal wait otherwise
        do_write(0, 8'h01, 1'b0, -1);
        check("clr_lat",     r_lat, 38);
        do_write(0, 8'h03, 1'b0, -1);
        check("home3_lat",   r_lat, 38);
        do_write(0, 8'h02, 1'b0, -1);
        check("home2_lat",   r_lat, 38);
        do_write(0, 8'h01, 1'b1, -1);
        check("data01_lat",  r_lat, 18);
        do_write(0, 8'h04, 1'b0, -1);
        check("ins04_lat",   r_lat, 18);
        do_write(0, 8'h80, 1'b0, -1);
        check("ins80_lat",   r_lat, 18);

        // 4-bit mode: two nibble transfers
        do_write(1, 8'hA5, 1'b1, -1);
        check("n_lat",     r_lat,    26);
        check("n_pulses",  r_pulses, 2);
        check("n_enhi",    r_enhi,   8);
        check("n_first",   r_first,  2);
        check("n_hi",      r_pdata0, 8'hA0);
        check("n_lo",      r_pdata1, 8'h50);
        check("n_dstable", r_dbad,   0);
        check("n_rs",      m_rs,     1);
        do_write(1, 8'h01, 1'b0, -1);
        check("n_clr_lat", r_lat,    46);
        check("n_clr_hi",  r_pdata0, 8'h00);
        check("n_clr_lo",  r_pdata1, 8'h10);

        // Start pulse while busy is dropped
        do_write(0, 8'h42, 1'b1, 5);
        check("busy_drop_lat",    r_lat,    18);
        check("busy_drop_pulses", r_pulses, 1);
        repeat (3) step();
        check("busy_drop_idle",   busy0,    0);

        // Start edge in the same cycle odone rises is dropped
        do_write(0, 8'h43, 1'b1, 17);
        check("b2b_same_lat", r_lat, 18);
        repeat (3) step();
        check("b2b_same_idle", busy0, 0);
        check("b2b_same_done", done0, 1);

        // Start edge one cycle after odone is accepted
        do_write(0, 8'h44, 1'b1, -1);
        check("b2b_first_lat", r_lat, 18);
        istart0 = 1'b1;
        step();
        istart0 = 1'b0;
        check("b2b_next_busy", busy0, 1);
        check("b2b_next_done", done0, 0);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done0) begin
                seen = 1;
                break;
            end
            step();
        end
        check("b2b_next_finish", seen, 1);

        // Asynchronous reset mid-write
        idata   = 8'h41;
        irs     = 1'b1;
        istart0 = 1'b1;
        step();
        istart0 = 1'b0;
        repeat (3) step();
        check("mid_en_high", en0, 1);
        #2 irst_n = 1'b0;
        #1;
        check("mid_rst_en",   en0,   0);
        check("mid_rst_done", done0, 0);
        check("mid_rst_busy", busy0, 0);
        istart0 = 1'b1;
        repeat (2) step();
        #2 irst_n = 1'b1;
        repeat (5) step();
        check("rel_held_busy", busy0, 0);
        check("rel_held_en",   en0,   0);
        istart0 = 1'b0;
        step();
        idata   = 8'h30;
        istart0 = 1'b1;
        step();
        istart0 = 1'b0;
        check("rel_new_busy", busy0, 1);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done0) begin
                seen = 1;
                break;
            end
            step();
        end
        check("rel_new_finish", seen, 1);
        check("rel_new_data",   data0, 8'h30);

        // istart held high for 40 cycles gives exactly one write
        idata      = 8'h48;
        irs        = 1'b1;
        pulses     = 0;
        done_rises = 0;
        prev_en    = en0;
        prev_done  = done0;
        istart0    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (en0 && !prev_en)     pulses++;
            if (done0 && !prev_done) done_rises++;
            prev_en   = en0;
            prev_done = done0;
        end
        istart0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (en0 && !prev_en)     pulses++;
            if (done0 && !prev_done) done_rises++;
            prev_en   = en0;
            prev_done = done0;
        end
        check("held_pulses", pulses,     1);
        check("held_done",   done_rises, 1);
        check("held_idle",   busy0,      0);

        check("rw_low", rw_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_writer.md
Name: lcd_bus_writer

Overview:
- Parameterised successor of the single-write LCD strobe engine: performs one complete HD44780-style write (setup, enable pulse, hold, execution wait) per rising edge of istart.
- Adds compile-time 8-bit/4-bit bus mode, programmable timing, and an automatic long execution wait for clear/home instructions.
- Host sequencers (init ROM walker, text writer) can therefore issue back-to-back writes without their own delay counters.
- Sits between the host sequencer and the LCD pins; write-only, so lcd_rw is tied low.

Parameters:
BUS4, 0, 0 = 8-bit bus (one transfer per write); 1 = 4-bit bus (high nibble, then low nibble)
SETUP_CYC, 2, cycles lcd_data/lcd_rs are stable before lcd_en rises (min 1)
EN_CYC, 26, cycles lcd_en is high per transfer (min 1)
HOLD_CYC, 2, cycles lcd_en is low with data held after the falling edge (min 1)
EXEC_CYC, 2000, post-write wait for normal instructions/data (min 1)
LONG_CYC, 82000, post-write wait for clear/home instructions (min 1)
CNT_W, 17, timing counter width; must hold max of all *_CYC values

Ports:
iclk  in  1  system clock, all logic on rising edge
irst_n  in  1  asynchronous active-low reset
idata  in  8  byte to write; sampled only on an accepted start
irs  in  1  register select (0 instruction, 1 data); sampled with idata
istart  in  1  start request; rising edge triggers a write
obusy  out  1  high from accepted start until write complete
odone  out  1  level; set on completion, cleared on next accepted start
lcd_data  out  8  LCD data bus; BUS4=1: nibble on [7:4], [3:0] driven 0
lcd_rw  out  1  constant 0
lcd_en  out  1  LCD enable strobe, registered
lcd_rs  out  1  latched irs

Behaviour:
- Reset (async, irst_n low): state IDLE, obusy=0, odone=0, lcd_en=0, lcd_data=0, lcd_rs=0, counter=0, nibble flag=0.
- Reset edge detector: prestart resets to 1, so istart held high through reset release does not trigger a write.
- Edge detect: prestart<=istart every cycle; start edge = istart & ~prestart.
- Edge while IDLE: accepted.
- Edge while obusy=1: dropped silently; no queueing, no effect on the current write.
- Accept edge (IDLE, start edge):
  - Latch idata/irs.
  - obusy<=1, odone<=0.
  - Drive lcd_data (BUS4=1: high nibble) and lcd_rs.
  - Go to SETUP with counter=0.
- States: IDLE -> SETUP -> EN_HI -> HOLD -> (BUS4 and first nibble ? SETUP with low nibble : EXEC) -> IDLE.
- SETUP lasts SETUP_CYC cycles; on exit lcd_en<=1.
- EN_HI: lcd_en is high for exactly EN_CYC cycles; on exit lcd_en<=0.
- HOLD lasts HOLD_CYC cycles.
- BUS4 nibble switch: at HOLD exit after the high nibble, lcd_data[7:4]<=latched low nibble and the nibble flag is set. The second SETUP begins the next cycle.
- EXEC lasts EXEC_CYC cycles. It lasts LONG_CYC instead when latched irs=0 and latched data[7:1]==7'b0000000 with data[0]=1 (0x01 clear), or data[7:1]==7'b0000001 (0x02/0x03 home).
- EXEC exit edge: state IDLE, obusy<=0, odone<=1. lcd_data and lcd_rs keep their last values.
- Latency, accept edge to odone edge:
  - BUS4=0: SETUP_CYC+EN_CYC+HOLD_CYC+EXEC_CYC.
  - BUS4=1: 2*(SETUP_CYC+EN_CYC+HOLD_CYC)+EXEC_CYC.
  - Substitute LONG_CYC for EXEC_CYC on clear/home.
- Back-to-back: a start edge arriving in the same cycle odone rises (state still EXEC) is dropped. A start edge one cycle later is accepted.
- lcd_en never glitches: it is a register output and is only set on SETUP exit.
- Reset mid-write: lcd_en drops immediately (async), odone=0, and the write is abandoned; no resume after release.

Test Plan:
Use SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, LONG_CYC=30, CNT_W=8.
1. BUS4=0, idata=0x41, irs=1, istart pulse -> lcd_data=0x41, lcd_rs=1; lcd_en high exactly 4 cycles starting 2 cycles after accept; odone rises 18 cycles after accept; obusy high for those 18 cycles.
2. BUS4=0, idata=0x01, irs=0 -> odone at 38 cycles. Repeat with 0x03 -> 38 cycles. Repeat with 0x01, irs=1 -> 18 cycles. Repeat with 0x04, irs=0 -> 18 cycles.
3. BUS4=1, idata=0xA5, irs=1 -> two lcd_en pulses of 4 cycles each; lcd_data=0xA0 during the first, 0x50 during the second; odone at 26 cycles.
4. Second istart pulse 5 cycles after the first accept (busy) -> ignored; exactly one set of lcd_en pulses; odone at 18. Third pulse 1 cycle after odone -> accepted, odone drops.
5. Assert irst_n=0 during EN_HI -> lcd_en=0 and odone=0 asynchronously. Release with istart held high -> no write (obusy stays 0) until istart falls and rises again.
6. istart held high for 40 cycles -> exactly one write. lcd_rw=0 throughout all tests.
